// File: rtl/fetch_request_sequencer_pkg.sv
// Shared parameters for the fetch request sequencer: datapath width, boot
// address, sequential PC step, FSM state encodings and next-PC selector.
package fetch_request_sequencer_pkg;

    localparam int                    WORD_WIDTH  = 32;
    localparam logic [WORD_WIDTH-1:0] BOOT_ADDR   = 32'h0000_1000;
    localparam logic [WORD_WIDTH-1:0] INSTR_BYTES = WORD_WIDTH'(4);

    // REQ issues a read, WAIT has one outstanding, HOLD presents a stalled word.
    typedef enum logic [1:0] {
        FS_REQ  = 2'd0,
        FS_WAIT = 2'd1,
        FS_HOLD = 2'd2
    } fetch_state_e;

    // Source of the next fetch PC.
    typedef enum logic [1:0] {
        PC_HOLD     = 2'd0,
        PC_SEQ      = 2'd1,
        PC_REDIRECT = 2'd2
    } pc_sel_e;

    // Redirect targets are forced onto an instruction boundary.
    function automatic logic [WORD_WIDTH-1:0] word_align(input logic [WORD_WIDTH-1:0] addr);
        return addr & ~{{(WORD_WIDTH-2){1'b0}}, 2'b11};
    endfunction

endpackage

// File: rtl/fetch_request_sequencer_next_pc.sv
// Next-PC mux for the fetch sequencer: keep the current PC, step past the
// word just fetched, or take an aligned redirect target.
module fetch_next_pc
    import fetch_request_sequencer_pkg::*;
(
    input  pc_sel_e               sel_in,
    input  logic [WORD_WIDTH-1:0] pc_in,
    input  logic [WORD_WIDTH-1:0] fetch_addr_in,
    input  logic [WORD_WIDTH-1:0] redirect_addr_in,
    output logic [WORD_WIDTH-1:0] pc_out
);

    // Select the next PC; the sequential step wraps naturally at 2^WORD_WIDTH.
    always_comb begin
        // NOTE: assign a default before the case so no path leaves pc_out unassigned (no latch).
        pc_out = pc_in;
        unique case (sel_in)
            PC_SEQ:      pc_out = fetch_addr_in + INSTR_BYTES;
            PC_REDIRECT: pc_out = word_align(redirect_addr_in);
            default:     pc_out = pc_in;
        endcase
    end

endmodule

// File: rtl/fetch_request_sequencer.sv
// Fetch request sequencer: owns the fetch PC (rm0), issues one I-cache read
// per instruction, waits for completion and presents {rm0, instruction, valid}
// to the fetch pipeline registers. Handles decode stall and branch redirects;
// a redirect that overtakes an outstanding read marks it to be discarded.
module fetch_request_sequencer
    import fetch_request_sequencer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall_in,
    input  logic                  redirect_in,
    input  logic [WORD_WIDTH-1:0] redirect_addr_in,
    output logic                  cache_req_out,
    output logic [WORD_WIDTH-1:0] cache_addr_out,
    input  logic                  cache_op_done_in,
    input  logic [WORD_WIDTH-1:0] cache_data_in,
    output logic [WORD_WIDTH-1:0] rm0_out,
    output logic [WORD_WIDTH-1:0] instruction_out,
    output logic                  valid_out
);

    fetch_state_e          state_q, state_d;
    logic [WORD_WIDTH-1:0] pc_q, pc_d;
    logic                  kill_q, kill_d;
    logic                  cache_req_q, cache_req_d;
    logic [WORD_WIDTH-1:0] cache_addr_q, cache_addr_d;
    logic [WORD_WIDTH-1:0] rm0_q, rm0_d;
    logic [WORD_WIDTH-1:0] instr_q, instr_d;
    logic                  valid_q, valid_d;
    pc_sel_e               pc_sel;

    fetch_next_pc u_next_pc (
        .sel_in           (pc_sel),
        .pc_in            (pc_q),
        .fetch_addr_in    (cache_addr_q),
        .redirect_addr_in (redirect_addr_in),
        .pc_out           (pc_d)
    );

    // Next-state and output decode; every register holds unless a branch below moves it.
    always_comb begin
        state_d      = state_q;
        kill_d       = kill_q;
        cache_req_d  = cache_req_q;
        cache_addr_d = cache_addr_q;
        rm0_d        = rm0_q;
        instr_d      = instr_q;
        valid_d      = valid_q;
        pc_sel       = PC_HOLD;

        unique case (state_q)
            FS_REQ: begin
                // Any presented word lasts only the one cycle spent in REQ.
                valid_d = 1'b0;
                if (redirect_in) begin
                    // The request is only raised on leaving REQ, so nothing is in
                    // flight yet: re-issue from the new PC on the next cycle.
                    pc_sel = PC_REDIRECT;
                end else begin
                    cache_req_d  = 1'b1;
                    cache_addr_d = pc_q;
                    state_d      = FS_WAIT;
                end
            end

            FS_WAIT: begin
                valid_d = 1'b0;
                if (cache_op_done_in) begin
                    cache_req_d = 1'b0;
                    kill_d      = 1'b0;
                    if (redirect_in) begin
                        // Word returned in the same cycle as a redirect is stale.
                        pc_sel  = PC_REDIRECT;
                        state_d = FS_REQ;
                    end else if (kill_q) begin
                        // Completion of a read overtaken by an earlier redirect.
                        state_d = FS_REQ;
                    end else begin
                        rm0_d   = cache_addr_q;
                        instr_d = cache_data_in;
                        valid_d = 1'b1;
                        pc_sel  = PC_SEQ;
                        state_d = stall_in ? FS_HOLD : FS_REQ;
                    end
                end else if (redirect_in) begin
                    // Keep the handshake going but drop whatever comes back.
                    pc_sel = PC_REDIRECT;
                    kill_d = 1'b1;
                end
            end

            FS_HOLD: begin
                // Outputs stay frozen with valid high until decode accepts them.
                if (redirect_in) begin
                    pc_sel  = PC_REDIRECT;
                    valid_d = 1'b0;
                    state_d = FS_REQ;
                end else if (!stall_in) begin
                    valid_d = 1'b0;
                    state_d = FS_REQ;
                end
            end

            default: begin
                state_d     = FS_REQ;
                cache_req_d = 1'b0;
                valid_d     = 1'b0;
                kill_d      = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state_q      <= FS_REQ;
            pc_q         <= BOOT_ADDR;
            kill_q       <= 1'b0;
            cache_req_q  <= 1'b0;
            cache_addr_q <= '0;
            rm0_q        <= '0;
            instr_q      <= '0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            kill_q       <= kill_d;
            cache_req_q  <= cache_req_d;
            cache_addr_q <= cache_addr_d;
            rm0_q        <= rm0_d;
            instr_q      <= instr_d;
            valid_q      <= valid_d;
        end
    end

    assign cache_req_out   = cache_req_q;
    assign cache_addr_out  = cache_addr_q;
    assign rm0_out         = rm0_q;
    assign instruction_out = instr_q;
    assign valid_out       = valid_q;

endmodule

// File: tb/tb_fetch_request_sequencer.sv
// Bench for fetch_request_sequencer. A cache responder and a transaction-level
// model live in step(): the model tracks the expected next fetch address, which
// reads are discarded by redirects, and which words must be presented and held.
module tb_fetch_request_sequencer;

    localparam logic [31:0] BOOT = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_in;
    logic        redirect_in;
    logic [31:0] redirect_addr_in;
    logic        cache_req_out;
    logic [31:0] cache_addr_out;
    logic        cache_op_done_in;
    logic [31:0] cache_data_in;
    logic [31:0] rm0_out;
    logic [31:0] instruction_out;
    logic        valid_out;

    always #5 clk = ~clk;

    fetch_request_sequencer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall_in         (stall_in),
        .redirect_in      (redirect_in),
        .redirect_addr_in (redirect_addr_in),
        .cache_req_out    (cache_req_out),
        .cache_addr_out   (cache_addr_out),
        .cache_op_done_in (cache_op_done_in),
        .cache_data_in    (cache_data_in),
        .rm0_out          (rm0_out),
        .instruction_out  (instruction_out),
        .valid_out        (valid_out)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model / responder state.
    bit          pending, killed, holding, exp_valid, stray_done;
    int          lat_cnt, lat_cfg, idle, n_accepted;
    logic [31:0] next_addr, held_pc, held_word, salt;

    // Memory contents: a fixed pattern per address, optionally salted.
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return salt ^ (32'hAAAA_0000 + ((a - BOOT) >> 2) + 32'd1);
    endfunction

    // One clock cycle: respond as the cache, update the model, check after the edge.
    task automatic step();
        bit          done_now, red_now, stall_now, rst_now, acc, p_req;
        logic [31:0] p_addr, word;
        done_now = 1'b0;
        p_req    = (cache_req_out === 1'b1);
        p_addr   = cache_addr_out;
        if (rst_n && pending && p_req) begin
            if (lat_cnt == 0) done_now = 1'b1;
            else lat_cnt--;
        end
        word             = word_of(p_addr);
        cache_op_done_in = done_now || stray_done;
        cache_data_in    = done_now ? word : 32'hDEAD_BEEF;
        red_now   = redirect_in;
        stall_now = stall_in;
        rst_now   = !rst_n;
        acc       = 1'b0;
        if (rst_now) begin
            pending = 0; killed = 0; holding = 0; exp_valid = 0; idle = 0;
            next_addr = BOOT;
        end else begin
            if (p_req && red_now) killed = 1;
            if (done_now) begin
                pending = 0;
                if (!killed) begin
                    acc = 1; held_pc = p_addr; held_word = word;
                    next_addr = p_addr + 32'd4; n_accepted++;
                end
                killed = 0;
            end
            if (red_now) next_addr = {redirect_addr_in[31:2], 2'b00};
            exp_valid = acc || (holding && stall_now && !red_now);
            holding   = acc ? stall_now : (holding && stall_now && !red_now);
        end

        @(posedge clk);
        #1;

        if (rst_now) begin
            n_checks++;
            if ({cache_req_out, cache_addr_out, rm0_out, instruction_out, valid_out} !== '0) begin
                n_fail++;
                $display("FAIL reset_outs t=%0t got req=%b addr=%h rm0=%h instr=%h valid=%b want all 0",
                         $time, cache_req_out, cache_addr_out, rm0_out, instruction_out, valid_out);
            end
        end else begin
            n_checks++;
            if (valid_out !== exp_valid) begin
                n_fail++;
                $display("FAIL valid t=%0t got %b want %b", $time, valid_out, exp_valid);
            end
            if (exp_valid) begin
                n_checks++;
                if ({rm0_out, instruction_out} !== {held_pc, held_word}) begin
                    n_fail++;
                    $display("FAIL presented t=%0t got rm0=%h instr=%h want rm0=%h instr=%h",
                             $time, rm0_out, instruction_out, held_pc, held_word);
                end
            end
            n_checks++;
            if ((valid_out === 1'b1) && (cache_req_out === 1'b1)) begin
                n_fail++;
                $display("FAIL req_while_valid t=%0t got req=1 valid=1 want req=0", $time);
            end
            if (p_req) begin
                n_checks++;
                if (cache_req_out !== !done_now) begin
                    n_fail++;
                    $display("FAIL req_level t=%0t got %b want %b", $time, cache_req_out, !done_now);
                end else if (!done_now) begin
                    n_checks++;
                    if (cache_addr_out !== p_addr) begin
                        n_fail++;
                        $display("FAIL addr_stable t=%0t got %h want %h", $time, cache_addr_out, p_addr);
                    end
                end
            end else if (cache_req_out === 1'b1) begin
                n_checks++;
                if (cache_addr_out !== next_addr) begin
                    n_fail++;
                    $display("FAIL req_addr t=%0t got %h want %h", $time, cache_addr_out, next_addr);
                end
                pending = 1; killed = 0;
                lat_cnt = ((lat_cfg > 0) ? lat_cfg : int'($urandom_range(4, 1))) - 1;
            end
            idle = ((cache_req_out === 1'b1) || holding || red_now) ? 0 : idle + 1;
            n_checks++;
            if (idle > 2) begin
                n_fail++;
                $display("FAIL idle t=%0t got %0d cycles without request want <= 2", $time, idle);
                idle = 0;
            end
        end
    endtask

    task automatic apply_reset();
        rst_n = 0; stall_in = 0; redirect_in = 0; redirect_addr_in = '0; stray_done = 0;
        step();
        step();
        rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0; stall_in = 0; redirect_in = 0; redirect_addr_in = '0; stray_done = 0;
        step();
        step();
        n_checks++;
        if ({cache_req_out, cache_addr_out, rm0_out, instruction_out, valid_out} !== '0) begin
            n_fail++;
            $display("FAIL test_reset_zero got req=%b addr=%h valid=%b want 0", cache_req_out, cache_addr_out, valid_out);
        end
        rst_n = 1;
        step();
        n_checks++;
        if ({cache_req_out, cache_addr_out} !== {1'b1, BOOT}) begin
            n_fail++;
            $display("FAIL test_reset_release got req=%b addr=%h want req=1 addr=%h", cache_req_out, cache_addr_out, BOOT);
        end
    endtask

    task automatic test_sequential();
        apply_reset();
        step();
        step();
        step();
        n_checks++;
        if (valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL seq_early_valid got %b want 0", valid_out);
        end
        step();
        n_checks++;
        if ({valid_out, rm0_out, instruction_out} !== {1'b1, 32'h0000_1000, 32'hAAAA_0001}) begin
            n_fail++;
            $display("FAIL seq_first got valid=%b rm0=%h instr=%h want 1 00001000 aaaa0001", valid_out, rm0_out, instruction_out);
        end
        step();
        n_checks++;
        if ({valid_out, cache_req_out, cache_addr_out} !== {1'b0, 1'b1, 32'h0000_1004}) begin
            n_fail++;
            $display("FAIL seq_reissue got valid=%b req=%b addr=%h want 0 1 00001004", valid_out, cache_req_out, cache_addr_out);
        end
        step();
        step();
        step();
        n_checks++;
        if ({valid_out, rm0_out, instruction_out} !== {1'b1, 32'h0000_1004, 32'hAAAA_0002}) begin
            n_fail++;
            $display("FAIL seq_second got valid=%b rm0=%h instr=%h want 1 00001004 aaaa0002", valid_out, rm0_out, instruction_out);
        end
    endtask

    task automatic test_stall();
        apply_reset();
        stall_in = 1;
        step();
        for (int i = 0; i < 20 && valid_out !== 1'b1; i++) step();
        n_checks++;
        if ({valid_out, rm0_out} !== {1'b1, 32'h0000_1000}) begin
            n_fail++;
            $display("FAIL stall_first got valid=%b rm0=%h want 1 00001000", valid_out, rm0_out);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if ({valid_out, cache_req_out, rm0_out, instruction_out} !== {2'b10, 32'h0000_1000, 32'hAAAA_0001}) begin
                n_fail++;
                $display("FAIL stall_frozen cycle %0d got valid=%b req=%b rm0=%h instr=%h", i, valid_out, cache_req_out, rm0_out, instruction_out);
            end
        end
        stall_in = 0;
        step();
        n_checks++;
        if (valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_release_valid got %b want 0", valid_out);
        end
        step();
        n_checks++;
        if ({cache_req_out, cache_addr_out} !== {1'b1, 32'h0000_1004}) begin
            n_fail++;
            $display("FAIL stall_release_req got req=%b addr=%h want 1 00001004", cache_req_out, cache_addr_out);
        end
    endtask

    task automatic test_redirect_wait();
        apply_reset();
        step();
        step();
        redirect_in = 1; redirect_addr_in = 32'h0000_2003;
        step();
        redirect_in = 0;
        step();
        n_checks++;
        if ({valid_out, cache_req_out} !== 2'b00) begin
            n_fail++;
            $display("FAIL redir_drop got valid=%b req=%b want 0 0", valid_out, cache_req_out);
        end
        step();
        n_checks++;
        if ({cache_req_out, cache_addr_out} !== {1'b1, 32'h0000_2000}) begin
            n_fail++;
            $display("FAIL redir_req got req=%b addr=%h want 1 00002000", cache_req_out, cache_addr_out);
        end
        for (int i = 0; i < 20 && valid_out !== 1'b1; i++) step();
        n_checks++;
        if ({valid_out, rm0_out, instruction_out} !== {1'b1, 32'h0000_2000, word_of(32'h0000_2000)}) begin
            n_fail++;
            $display("FAIL redir_present got valid=%b rm0=%h instr=%h want rm0=00002000", valid_out, rm0_out, instruction_out);
        end
    endtask

    task automatic test_redirect_with_done();
        apply_reset();
        step();
        step();
        step();
        redirect_in = 1; redirect_addr_in = 32'h0000_3000;
        step();
        redirect_in = 0;
        n_checks++;
        if ({valid_out, cache_req_out} !== 2'b00) begin
            n_fail++;
            $display("FAIL redir_done_drop got valid=%b req=%b want 0 0", valid_out, cache_req_out);
        end
        step();
        n_checks++;
        if ({cache_req_out, cache_addr_out} !== {1'b1, 32'h0000_3000}) begin
            n_fail++;
            $display("FAIL redir_done_req got req=%b addr=%h want 1 00003000", cache_req_out, cache_addr_out);
        end
    endtask

    task automatic test_redirect_hold();
        apply_reset();
        stall_in = 1;
        step();
        for (int i = 0; i < 20 && valid_out !== 1'b1; i++) step();
        step();
        redirect_in = 1; redirect_addr_in = 32'h0000_4001;
        step();
        redirect_in = 0;
        n_checks++;
        if (valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL redir_hold_valid got %b want 0", valid_out);
        end
        step();
        n_checks++;
        if ({cache_req_out, cache_addr_out} !== {1'b1, 32'h0000_4000}) begin
            n_fail++;
            $display("FAIL redir_hold_req got req=%b addr=%h want 1 00004000", cache_req_out, cache_addr_out);
        end
        stall_in = 0;
    endtask

    task automatic test_wrap();
        apply_reset();
        step();
        redirect_in = 1; redirect_addr_in = 32'hFFFF_FFFC;
        step();
        redirect_in = 0;
        for (int i = 0; i < 20 && valid_out !== 1'b1; i++) step();
        n_checks++;
        if ({valid_out, rm0_out} !== {1'b1, 32'hFFFF_FFFC}) begin
            n_fail++;
            $display("FAIL wrap_present got valid=%b rm0=%h want 1 fffffffc", valid_out, rm0_out);
        end
        step();
        n_checks++;
        if ({cache_req_out, cache_addr_out} !== {1'b1, 32'h0000_0000}) begin
            n_fail++;
            $display("FAIL wrap_next got req=%b addr=%h want 1 00000000", cache_req_out, cache_addr_out);
        end
    endtask

    task automatic test_reset_mid_wait();
        apply_reset();
        step();
        step();
        rst_n = 0; stray_done = 1;
        step();
        n_checks++;
        if ({cache_req_out, valid_out} !== 2'b00) begin
            n_fail++;
            $display("FAIL midreset_req got req=%b valid=%b want 0 0", cache_req_out, valid_out);
        end
        rst_n = 1;
        step();
        stray_done = 0;
        n_checks++;
        if ({cache_req_out, cache_addr_out, valid_out} !== {1'b1, BOOT, 1'b0}) begin
            n_fail++;
            $display("FAIL midreset_restart got req=%b addr=%h valid=%b want 1 00001000 0", cache_req_out, cache_addr_out, valid_out);
        end
        for (int i = 0; i < 20 && valid_out !== 1'b1; i++) step();
        n_checks++;
        if ({valid_out, rm0_out, instruction_out} !== {1'b1, BOOT, 32'hAAAA_0001}) begin
            n_fail++;
            $display("FAIL midreset_present got valid=%b rm0=%h instr=%h want 1 00001000 aaaa0001", valid_out, rm0_out, instruction_out);
        end
    endtask

    task automatic test_random();
        int start;
        apply_reset();
        salt    = $urandom;
        lat_cfg = 0;
        start   = n_accepted;
        step();
        for (int i = 0; i < 800; i++) begin
            stall_in         = ($urandom_range(3, 0) == 0);
            redirect_in      = !redirect_in && ($urandom_range(11, 0) == 0);
            redirect_addr_in = $urandom;
            step();
        end
        stall_in = 0; redirect_in = 0;
        for (int i = 0; i < 10; i++) step();
        n_checks++;
        if (n_accepted - start < 40) begin
            n_fail++;
            $display("FAIL random_throughput got %0d instructions want >= 40", n_accepted - start);
        end
    endtask

    initial begin
        salt = '0; lat_cfg = 3; n_accepted = 0;
        cache_op_done_in = 0; cache_data_in = '0;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_wait();
        test_redirect_with_done();
        test_redirect_hold();
        test_wrap();
        test_reset_mid_wait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no completion by t=%0t want run to end", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
